// File: rtl/amdc_ecs_sample_averager_if.sv
// amdc_ecs_sample_averager_if: raw ADC sample stream in, averaged result stream out
interface amdc_ecs_sample_averager_if #(
  parameter int DATA_W = 18,
  parameter int CNT_W  = 16
);
  logic              adc_done;
  logic [DATA_W-1:0] adc_data_x;
  logic [DATA_W-1:0] adc_data_y;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  modport master (
    output adc_done, adc_data_x, adc_data_y,
    input  out_x, out_y, out_valid, out_count
  );
  modport slave (
    input  adc_done, adc_data_x, adc_data_y,
    output out_x, out_y, out_valid, out_count
  );
endinterface

// File: rtl/amdc_ecs_sample_averager.sv
// amdc_ecs_sample_averager: offset-corrected, saturating power-of-two block averager for ECS X/Y samples
module amdc_ecs_sample_averager #(
  parameter int DATA_W       = 18,
  parameter int MAX_LOG2_AVG = 4,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  amdc_ecs_sample_averager_if.slave bus,
  input  logic [DATA_W-1:0]         offset_x,
  input  logic [DATA_W-1:0]         offset_y,
  input  logic [2:0]                avg_log2,
  input  logic                      clear,
  output logic                      sat_x,
  output logic                      sat_y
);
  localparam int ACC_W = DATA_W + MAX_LOG2_AVG;
  localparam logic [2:0] L_MAX = 3'(MAX_LOG2_AVG);
  typedef enum logic {FILL, EMIT} state_t;
  state_t state, state_next;
  logic done_q, new_sample, s1_valid, ovf_x, ovf_y, last, emit;
  logic [DATA_W:0] diff_x, diff_y;
  logic [DATA_W-1:0] corr_x, corr_y, avg_x, avg_y;
  logic signed [ACC_W-1:0] acc_x, acc_y, sum_x, sum_y;
  logic [MAX_LOG2_AVG-1:0] cnt;
  logic [2:0] l_q, l_new, l_cur;
  assign new_sample = bus.adc_done & ~done_q;
  assign diff_x = {bus.adc_data_x[DATA_W-1], bus.adc_data_x} - {offset_x[DATA_W-1], offset_x};
  assign diff_y = {bus.adc_data_y[DATA_W-1], bus.adc_data_y} - {offset_y[DATA_W-1], offset_y};
  assign ovf_x = diff_x[DATA_W] ^ diff_x[DATA_W-1];
  assign ovf_y = diff_y[DATA_W] ^ diff_y[DATA_W-1];
  // The first sample of a block picks up the live exponent; later samples reuse the latched one
  assign l_new = avg_log2 > L_MAX ? L_MAX : avg_log2;
  assign l_cur = cnt == '0 ? l_new : l_q;
  assign last = cnt == ~({MAX_LOG2_AVG{1'b1}} << l_cur);
  assign sum_x = acc_x + {{MAX_LOG2_AVG{corr_x[DATA_W-1]}}, corr_x};
  assign sum_y = acc_y + {{MAX_LOG2_AVG{corr_y[DATA_W-1]}}, corr_y};
  assign avg_x = DATA_W'(sum_x >>> l_cur);
  assign avg_y = DATA_W'(sum_y >>> l_cur);
  assign emit = s1_valid & last & ~clear;
  assign bus.out_valid = state == EMIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_next;
  always_comb begin
    state_next = FILL;
    state_next = emit ? EMIT : state_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q        <= 1'b0;
      s1_valid      <= 1'b0;
      corr_x        <= '0;
      corr_y        <= '0;
      sat_x         <= 1'b0;
      sat_y         <= 1'b0;
      acc_x         <= '0;
      acc_y         <= '0;
      cnt           <= '0;
      l_q           <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_count <= '0;
    end else begin
      done_q <= bus.adc_done;
      if (clear) begin
        s1_valid <= 1'b0;
        sat_x    <= 1'b0;
        sat_y    <= 1'b0;
        acc_x    <= '0;
        acc_y    <= '0;
        cnt      <= '0;
      end else begin
        s1_valid <= new_sample;
        if (new_sample) begin
          corr_x <= ovf_x ? {diff_x[DATA_W], {(DATA_W-1){~diff_x[DATA_W]}}} : diff_x[DATA_W-1:0];
          corr_y <= ovf_y ? {diff_y[DATA_W], {(DATA_W-1){~diff_y[DATA_W]}}} : diff_y[DATA_W-1:0];
          sat_x  <= sat_x | ovf_x;
          sat_y  <= sat_y | ovf_y;
        end
        if (s1_valid) begin
          if (cnt == '0) l_q <= l_new;
          if (last) begin
            bus.out_x     <= avg_x;
            bus.out_y     <= avg_y;
            bus.out_count <= bus.out_count + 1'b1;
            acc_x         <= '0;
            acc_y         <= '0;
            cnt           <= '0;
          end else begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            cnt   <= cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_amdc_ecs_sample_averager.sv
// tb_amdc_ecs_sample_averager: directed and randomized checks against a block-average reference model
module tb_amdc_ecs_sample_averager;
  logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0;
  logic [17:0] offset_x = '0, offset_y = '0;
  logic [2:0] avg_log2 = '0;
  logic sat_x, sat_y;
  int checks = 0, failures = 0, npulse = 0, cyc = 0, p0;
  amdc_ecs_sample_averager_if #(.DATA_W(18), .CNT_W(16)) bus ();
  amdc_ecs_sample_averager #(.DATA_W(18), .MAX_LOG2_AVG(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .offset_x(offset_x), .offset_y(offset_y),
    .avg_log2(avg_log2), .clear(clear), .sat_x(sat_x), .sat_y(sat_y)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask
  function automatic int sx(input logic [17:0] v);
    return int'($signed(v));
  endfunction
  function automatic int sat_corr(input logic [17:0] d, input logic [17:0] o, output bit ovf);
    int v = sx(d) - sx(o);
    ovf = (v > 131071) || (v < -131072);
    return v > 131071 ? 131071 : (v < -131072 ? -131072 : v);
  endfunction
  function automatic int fdiv(input int s, input int n);
    int q = s / n;
    if (s % n != 0 && s < 0) q--;
    return q;
  endfunction
  // Reference: a sample is the rising edge of adc_done, joins its block one clock later,
  // and a full block's floor-mean becomes visible after that clock.
  int bx[$], by[$];
  int blen, p_x, p_y;
  bit m_valid, m_satx, m_saty, prev_done, p_valid, ovx, ovy;
  logic [17:0] m_x, m_y;
  logic [15:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx.delete(); by.delete();
      blen = 1; m_valid = 0; m_satx = 0; m_saty = 0; prev_done = 0; p_valid = 0;
      m_x = '0; m_y = '0; m_cnt = '0;
    end else begin
      m_valid = 0;
      if (clear) begin
        bx.delete(); by.delete();
        p_valid = 0; m_satx = 0; m_saty = 0;
      end else begin
        if (p_valid) begin
          if (bx.size() == 0) blen = 1 << (avg_log2 > 3'd4 ? 4 : int'(avg_log2));
          bx.push_back(p_x); by.push_back(p_y);
          if (bx.size() == blen) begin
            m_x = 18'(fdiv(bx.sum(), blen));
            m_y = 18'(fdiv(by.sum(), blen));
            m_valid = 1;
            m_cnt++;
            bx.delete(); by.delete();
          end
        end
        p_valid = bus.adc_done && !prev_done;
        if (p_valid) begin
          p_x = sat_corr(bus.adc_data_x, offset_x, ovx);
          p_y = sat_corr(bus.adc_data_y, offset_y, ovy);
          m_satx |= ovx;
          m_saty |= ovy;
        end
      end
      prev_done = bus.adc_done;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (bus.out_valid) npulse++;
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_x", bus.out_x, m_x);
    chk("out_y", bus.out_y, m_y);
    chk("out_count", bus.out_count, m_cnt);
    chk("sat_x", sat_x, m_satx);
    chk("sat_y", sat_y, m_saty);
  end
  // clr: 0 none, 1 with the rising edge, 2 on the following clock
  task automatic txn(input logic [17:0] x, input logic [17:0] y, input int hold = 2,
                     input int gap = 3, input int clr = 0);
    @(negedge clk);
    bus.adc_data_x = x; bus.adc_data_y = y; bus.adc_done = 1'b1; clear = (clr == 1);
    for (int k = 1; k <= hold + gap; k++) begin
      @(negedge clk);
      clear = (clr == 2 && k == 1);
      if (k == hold) bus.adc_done = 1'b0;
    end
  endtask
  initial begin
    bus.adc_done = 1'b0; bus.adc_data_x = '0; bus.adc_data_y = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_x", bus.out_x, 0);
    chk("rst_out_count", bus.out_count, 0);
    rst_n = 1'b1;
    p0 = npulse;
    txn(18'h00100, 18'h3FF00, 50, 3);
    chk("single_pulses", npulse - p0, 1);
    chk("single_x", bus.out_x, 18'h00100);
    chk("single_y", bus.out_y, 18'h3FF00);
    chk("single_count", bus.out_count, 1);
    avg_log2 = 3'd2; p0 = npulse;
    for (int i = 10; i < 13; i++) txn(18'(i), '0);
    chk("avg_no_early_pulse", npulse - p0, 0);
    txn(18'd13, '0);
    chk("avg_pulses", npulse - p0, 1);
    chk("avg_x", bus.out_x, 11);
    chk("avg_count", bus.out_count, 2);
    avg_log2 = 3'd1;
    txn(18'h3FFFD, '0);
    txn(18'h3FFFC, '0);
    chk("neg_floor_x", bus.out_x, 18'h3FFFC);
    avg_log2 = 3'd0; offset_x = 18'h20000;
    txn(18'h1FFFF, '0);
    chk("sat_out_x", bus.out_x, 18'h1FFFF);
    chk("sat_x_set", sat_x, 1);
    chk("sat_y_clear", sat_y, 0);
    offset_x = '0;
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    @(negedge clk);
    chk("sat_x_after_clear", sat_x, 0);
    chk("sat_hold_x", bus.out_x, 18'h1FFFF);
    chk("sat_count", bus.out_count, 4);
    avg_log2 = 3'd2; p0 = npulse;
    txn(18'd50, '0); txn(18'd60, '0); txn(18'd70, '0, 2, 3, 1);
    chk("clear_discard_pulses", npulse - p0, 0);
    for (int i = 0; i < 4; i++) txn(18'(100 + 4 * i), '0);
    chk("clear_block_pulses", npulse - p0, 1);
    chk("clear_block_x", bus.out_x, 106);
    p0 = npulse;
    txn(18'd8, '0);
    avg_log2 = 3'd0;
    txn(18'd8, '0); txn(18'd8, '0);
    chk("avg_change_pending", npulse - p0, 0);
    txn(18'd8, '0);
    chk("avg_change_block", npulse - p0, 1);
    txn(18'd20, '0);
    chk("avg_change_l0_a", bus.out_x, 20);
    txn(18'd24, '0);
    chk("avg_change_l0_b", bus.out_x, 24);
    chk("avg_change_count", bus.out_count, 8);
    avg_log2 = 3'd7; p0 = npulse;
    for (int i = 0; i < 15; i++) txn(18'(i), '0, 1, 1);
    chk("clamp_no_early_pulse", npulse - p0, 0);
    txn(18'd15, '0);
    chk("clamp_pulses", npulse - p0, 1);
    chk("clamp_x", bus.out_x, 7);
    chk("clamp_count", bus.out_count, 9);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) avg_log2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        offset_x = 18'($urandom); offset_y = 18'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        offset_x = 18'($urandom_range(0, 2000)) - 18'd1000;
        offset_y = 18'($urandom_range(0, 2000)) - 18'd1000;
      end
      txn(18'($urandom), 18'($urandom), $urandom_range(1, 6), $urandom_range(0, 3),
          $urandom_range(0, 29) == 0 ? int'($urandom_range(1, 2)) : 0);
    end
    clear = 1'b0; offset_x = '0; offset_y = '0; avg_log2 = 3'd2;
    txn(18'd1, '0);
    @(negedge clk);
    bus.adc_data_x = 18'd5; bus.adc_data_y = '0; bus.adc_done = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", bus.out_x, 0);
    chk("async_rst_count", bus.out_count, 0);
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_sat_x", sat_x, 0);
    @(negedge clk);
    avg_log2 = 3'd0; rst_n = 1'b1; p0 = npulse;
    repeat (5) @(negedge clk);
    chk("post_rst_pulses", npulse - p0, 1);
    chk("post_rst_x", bus.out_x, 5);
    chk("post_rst_count", bus.out_count, 1);
    bus.adc_done = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
